// File: rtl/exc_sched.sv
// Commit-point exception/interrupt sequencer: picks one prioritised event per
// commit, drives CP0 exception/ERET inputs, flush and fetch redirect.
module exc_sched #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  ext_int,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_in_delay_slot,
    input  logic        commit_exc_valid,
    input  logic [4:0]  commit_exc_code,
    input  logic [31:0] commit_badvaddr,
    input  logic        commit_eret,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic        status_erl,
    input  logic [7:0]  status_im,
    input  logic [1:0]  cause_ip_sw,
    input  logic [31:0] epc,
    input  logic [31:0] count,
    input  logic [31:0] compare,
    input  logic        compare_we,
    output logic        count_tick,
    output logic [5:0]  hw_ip,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic        exc_in_delay_slot,
    output logic [31:0] exc_badvaddr,
    output logic        eret_out,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int              DIV_W   = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(COUNT_DIV - 1);

    typedef enum logic {IDLE, TAKE} state_t;

    state_t      state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic        timer_pend_q, timer_pend_d;
    logic [5:0]  sync1_q, sync2_q, hw_ip_q, hw_ip_d;
    logic        exc_valid_q, exc_valid_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        exc_ds_q, exc_ds_d;
    logic [31:0] exc_bva_q, exc_bva_d;
    logic        eret_q, eret_d;
    logic        flush_q, flush_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic [7:0]  ip;
    logic        int_pend;
    logic        take_evt;
    logic        is_exc;

    always_comb begin
        div_cnt_d    = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + DIV_W'(1);
        // Clear beats set when MTC0 Compare coincides with a match
        timer_pend_d = timer_pend_q;
        if (count == compare) timer_pend_d = 1'b1;
        if (compare_we)       timer_pend_d = 1'b0;
        hw_ip_d      = {sync2_q[5] | timer_pend_q, sync2_q[4:0]};

        ip       = {hw_ip_q, cause_ip_sw};
        int_pend = status_ie & ~status_exl & ~status_erl & (|(ip & status_im));
        take_evt = (state_q == IDLE) && commit_valid &&
                   (int_pend || commit_exc_valid || commit_eret);
        is_exc   = int_pend || commit_exc_valid;

        state_d       = IDLE;
        exc_valid_d   = 1'b0;
        exc_code_d    = '0;
        exc_pc_d      = '0;
        exc_ds_d      = 1'b0;
        exc_bva_d     = '0;
        eret_d        = 1'b0;
        flush_d       = 1'b0;
        redir_valid_d = 1'b0;
        redir_pc_d    = '0;

        // Interrupt outranks the synchronous exception, which outranks ERET
        if (take_evt) begin
            state_d       = TAKE;
            exc_valid_d   = is_exc;
            eret_d        = ~is_exc;
            exc_code_d    = (!int_pend && commit_exc_valid) ? commit_exc_code : 5'd0;
            exc_bva_d     = (!int_pend && commit_exc_valid) ? commit_badvaddr : 32'd0;
            exc_pc_d      = commit_pc;
            exc_ds_d      = commit_in_delay_slot;
            flush_d       = 1'b1;
            redir_valid_d = 1'b1;
            redir_pc_d    = is_exc ? EXC_VECTOR : epc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            div_cnt_q     <= '0;
            timer_pend_q  <= 1'b0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            hw_ip_q       <= '0;
            exc_valid_q   <= 1'b0;
            exc_code_q    <= '0;
            exc_pc_q      <= '0;
            exc_ds_q      <= 1'b0;
            exc_bva_q     <= '0;
            eret_q        <= 1'b0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            timer_pend_q  <= timer_pend_d;
            sync1_q       <= ext_int;
            sync2_q       <= sync1_q;
            hw_ip_q       <= hw_ip_d;
            exc_valid_q   <= exc_valid_d;
            exc_code_q    <= exc_code_d;
            exc_pc_q      <= exc_pc_d;
            exc_ds_q      <= exc_ds_d;
            exc_bva_q     <= exc_bva_d;
            eret_q        <= eret_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign count_tick        = (div_cnt_q == DIV_MAX);
    assign hw_ip             = hw_ip_q;
    assign exc_valid         = exc_valid_q;
    assign exc_code          = exc_code_q;
    assign exc_pc            = exc_pc_q;
    assign exc_in_delay_slot = exc_ds_q;
    assign exc_badvaddr      = exc_bva_q;
    assign eret_out          = eret_q;
    assign flush             = flush_q;
    assign redirect_valid    = redir_valid_q;
    assign redirect_pc       = redir_pc_q;

endmodule

// File: tb/tb_exc_sched.sv
// Scoreboard bench for exc_sched: stimulus pushes expected events, a negedge
// monitor pops and compares whenever the DUT presents one.
module tb_exc_sched;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  ext_int;
    logic        commit_valid, commit_in_delay_slot, commit_exc_valid, commit_eret;
    logic [31:0] commit_pc, commit_badvaddr, epc, count, compare;
    logic [4:0]  commit_exc_code;
    logic        status_ie, status_exl, status_erl, compare_we;
    logic [7:0]  status_im;
    logic [1:0]  cause_ip_sw;
    logic        count_tick, exc_valid, exc_in_delay_slot, eret_out, flush, redirect_valid;
    logic [5:0]  hw_ip;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_badvaddr, redirect_pc;

    typedef struct {
        logic        exc;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bva;
        logic [31:0] rpc;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    exc_sched #(.EXC_VECTOR(VEC), .COUNT_DIV(2)) dut (
        .clk(clk), .reset(reset), .ext_int(ext_int),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_in_delay_slot(commit_in_delay_slot),
        .commit_exc_valid(commit_exc_valid), .commit_exc_code(commit_exc_code),
        .commit_badvaddr(commit_badvaddr), .commit_eret(commit_eret),
        .status_ie(status_ie), .status_exl(status_exl), .status_erl(status_erl),
        .status_im(status_im), .cause_ip_sw(cause_ip_sw), .epc(epc),
        .count(count), .compare(compare), .compare_we(compare_we),
        .count_tick(count_tick), .hw_ip(hw_ip), .exc_valid(exc_valid),
        .exc_code(exc_code), .exc_pc(exc_pc), .exc_in_delay_slot(exc_in_delay_slot),
        .exc_badvaddr(exc_badvaddr), .eret_out(eret_out), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic e, input logic r, input logic [4:0] c,
                        input logic [31:0] pc, input logic ds,
                        input logic [31:0] bva, input logic [31:0] rpc);
        exp_t x;
        x.exc = e; x.eret = r; x.code = c; x.pc = pc; x.ds = ds;
        x.bva = bva; x.rpc = rpc; x.cyc = cyc + 1;
        sbq.push_back(x);
    endtask

    task automatic clr_commit();
        commit_valid = 0; commit_pc = 0; commit_in_delay_slot = 0;
        commit_exc_valid = 0; commit_exc_code = 0; commit_badvaddr = 0;
        commit_eret = 0;
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_exc_valid"}, exc_valid, 0);
        chk({nm, "_eret"}, eret_out, 0);
        chk({nm, "_flush"}, flush, 0);
        chk({nm, "_redirect_valid"}, redirect_valid, 0);
        chk({nm, "_redirect_pc"}, redirect_pc, 0);
        chk({nm, "_exc_pc"}, exc_pc, 0);
        chk({nm, "_exc_code"}, exc_code, 0);
        chk({nm, "_hw_ip"}, hw_ip, 0);
    endtask

    task automatic chk_tick_pattern(input string nm);
        chk({nm, "_tick0"}, count_tick, 0);
        step(); chk({nm, "_tick1"}, count_tick, 1);
        step(); chk({nm, "_tick2"}, count_tick, 0);
        step(); chk({nm, "_tick3"}, count_tick, 1);
    endtask

    // Monitor: any presented event must match the head of the scoreboard
    always @(negedge clk) begin
        if (exc_valid || eret_out || flush || redirect_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_event", {exc_valid, eret_out, flush, redirect_valid}, 0);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("ev_exc_valid", exc_valid, x.exc);
                chk("ev_eret", eret_out, x.eret);
                chk("ev_flush", flush, 1);
                chk("ev_redirect_valid", redirect_valid, 1);
                chk("ev_code", exc_code, x.code);
                chk("ev_pc", exc_pc, x.pc);
                chk("ev_ds", exc_in_delay_slot, x.ds);
                chk("ev_badvaddr", exc_badvaddr, x.bva);
                chk("ev_redirect_pc", redirect_pc, x.rpc);
                chk("ev_cycle", cyc, x.cyc);
            end
        end
    end

    initial begin
        reset = 1; ext_int = 0; clr_commit();
        status_ie = 0; status_exl = 0; status_erl = 0; status_im = 8'hFF;
        cause_ip_sw = 0; epc = 0; count = 0; compare = 32'hFFFF_FFFF; compare_we = 0;
        idle(3);
        chk_outputs_zero("por");
        reset = 0;
        chk_tick_pattern("por");
        idle(2);

        // Synchronous exception in a delay slot; TAKE-cycle commit ignored
        commit_valid = 1; commit_exc_valid = 1; commit_exc_code = 5'h04;
        commit_pc = 32'h8000_0104; commit_in_delay_slot = 1; commit_badvaddr = 32'h1233;
        push(1, 0, 5'h04, 32'h8000_0104, 1, 32'h1233, VEC);
        step();
        commit_exc_code = 5'h07; commit_eret = 1; commit_pc = 32'h8000_0108;
        step();
        clr_commit();
        idle(3);

        // Interrupt: synchroniser latency, priority over exception, no commit -> no event
        status_ie = 1; status_im = 8'hFF; ext_int = 6'b000100;
        step(); chk("int_hw_ip_t1", hw_ip, 6'h00);
        step(); chk("int_hw_ip_t2", hw_ip, 6'h00);
        step(); chk("int_hw_ip_t3", hw_ip, 6'h04);
        idle(2);
        commit_valid = 1; commit_exc_valid = 1; commit_exc_code = 5'd10;
        commit_pc = 32'h8000_0200; commit_badvaddr = 32'hDEAD_BEEF;
        push(1, 0, 5'd0, 32'h8000_0200, 0, 32'd0, VEC);
        step();
        step();
        clr_commit();
        idle(4);

        // Masked interrupt: EXL, ERL, IM[4]
        status_exl = 1; commit_valid = 1; commit_pc = 32'h8000_0210;
        idle(2);
        status_exl = 0; status_erl = 1;
        idle(2);
        status_erl = 0; status_im = 8'hEF;
        idle(2);
        clr_commit(); status_ie = 0; status_im = 8'hFF; ext_int = 0;
        idle(4);
        chk("int_clear_hw_ip", hw_ip, 6'h00);

        // Timer match, then compare_we coinciding with a match
        count = 32'h10; compare = 32'h10;
        step(); chk("timer_hw_ip5_t1", hw_ip[5], 0);
        count = 32'h11;
        step(); chk("timer_hw_ip5_t2", hw_ip[5], 1);
        count = 32'h20; compare = 32'h20; compare_we = 1;
        step();
        compare_we = 0; count = 32'h21;
        step(); chk("timer_clear_t2", hw_ip[5], 0);
        step(); chk("timer_clear_t3", hw_ip[5], 0);

        // ERET, with a second ERET in the TAKE cycle ignored
        commit_valid = 1; commit_eret = 1; commit_pc = 32'h8000_0300; epc = 32'h8000_2000;
        push(0, 1, 5'd0, 32'h8000_0300, 0, 32'd0, 32'h8000_2000);
        step();
        commit_pc = 32'h8000_0304; epc = 32'h8000_3000;
        step();
        clr_commit();
        idle(3);

        // Reset asserted during TAKE aborts and clears everything
        commit_valid = 1; commit_exc_valid = 1; commit_exc_code = 5'h05;
        commit_pc = 32'h8000_0400; commit_badvaddr = 32'h44;
        push(1, 0, 5'h05, 32'h8000_0400, 0, 32'h44, VEC);
        step();
        reset = 1; commit_exc_valid = 0; commit_eret = 1;
        step(); chk_outputs_zero("rst_take");
        idle(2);
        reset = 0; clr_commit();
        chk_tick_pattern("rst_take");
        idle(3);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
